ram_bank_router: RTL and testbench
==================================

Name: ram_bank_router

Overview:
- Clocked, parametrised successor of the two-bank RAM controller.
- Routes one CPU memory access (read or write) to one of NUM_BANKS RAM banks, selected by the top address bits.
- Drives a per-bank request/done handshake, registers the bank's feedback and returns a level work_done to the memory stage.
- Uses rising-edge detection of the bank done signal to reject stale completions, and a timeout to bound stalls.

Parameters:
- ADDR_W, 16, CPU address width.
- DATA_W, 16, data/feedback width.
- NUM_BANKS, 2, bank count; power of two, at least 2.
- BANK_BITS, 1, log2(NUM_BANKS).
- TIMEOUT_CYC, 255, max cycles in BUSY; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_rd  in  1  read request; level, held until work_done.
- mem_wr  in  1  write request; level, held until work_done.
- addr  in  ADDR_W  access address.
- wdata  in  DATA_W  write data.
- ram_work_done  in  NUM_BANKS  per-bank done, level.
- ram_feedback  in  NUM_BANKS*DATA_W  bank k occupies bits [k*DATA_W +: DATA_W].
- ram_need_to_work  out  NUM_BANKS  one-hot bank request.
- ram_rd, ram_wr  out  1 each  latched operation, valid while a need bit is high.
- ram_addr  out  ADDR_W  latched address.
- ram_wdata  out  DATA_W  latched write data.
- work_done  out  1  access complete, or no access pending.
- feedback  out  DATA_W  registered read result.
- timeout_err  out  1  last access timed out.

Behaviour:
- Reset, applied on any clk edge with rst=1 and in any state:
  - state=IDLE.
  - ram_need_to_work=0, ram_rd=ram_wr=0, ram_addr=0, ram_wdata=0.
  - feedback=0, timeout_err=0, work_done=1, timer=0, done_prev=0.
  - An in-flight bank request is abandoned; need drops at that same edge.
- Bank select: sel = addr[ADDR_W-1 -: BANK_BITS], latched at accept. Bank 0 covers the lowest addresses.
- done_prev registers ram_work_done every cycle.
- A completion is a rise on the selected bank: ram_work_done[sel]=1 and done_prev[sel]=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - work_done=1 while mem_rd=mem_wr=0.
  - On an edge with mem_rd|mem_wr: latch addr, wdata and sel.
  - Operation: ram_wr=mem_wr, ram_rd=mem_rd & ~mem_wr; write wins if both are high.
  - Set ram_need_to_work = 1<<sel, clear timeout_err and timer, go BUSY.
  - work_done is combinationally 0 in the accept cycle: work_done = (state==DONE) | (state==IDLE & ~mem_rd & ~mem_wr).
- BUSY:
  - need stays asserted; timer increments each cycle.
  - On a completion edge: feedback <= ram_feedback[sel] (captured for writes too), need<=0, go DONE.
  - Timeout, when TIMEOUT_CYC != 0 and timer == TIMEOUT_CYC-1 with no completion: feedback <= all ones, timeout_err<=1, need<=0, go DONE.
  - Completion and timeout in the same cycle: completion wins, timeout_err stays 0.
  - Done activity on non-selected banks is ignored.
- DONE:
  - work_done=1, feedback held.
  - Return to IDLE only on an edge with mem_rd=mem_wr=0. This prevents re-issue of a held request.
- A done level already high at accept does not count as completion. The bank must drop it and raise it again.
- Latency: accept at edge N, need high after N. Done rising before edge M means feedback valid and work_done=1 after M. Minimum request-to-work_done is 2 edges.
- Outputs other than work_done are registered.

Test Plan:
- Read, bank 1: NUM_BANKS=2, mem_rd=1, addr=16'h8004. need=2'b10 after 1 edge. Bank raises done with feedback 16'hBEEF 3 cycles later. Next edge: feedback=16'hBEEF, work_done=1, need=0. Drop mem_rd: IDLE, no second request.
- Write, bank 0, with both rd and wr: mem_wr=mem_rd=1, addr=16'h0010, wdata=16'h1234. ram_wr=1, ram_rd=0, need=2'b01, ram_wdata=16'h1234, ram_addr=16'h0010.
- Stale done: ram_work_done[0] held 1 from a prior access; new read to bank 0. No completion until done falls and rises again; work_done stays 0 meanwhile.
- Timeout: TIMEOUT_CYC=8, bank never responds. After 8 BUSY cycles: feedback=16'hFFFF, timeout_err=1, need=0. Next accepted request clears timeout_err.
- Reset mid-BUSY: rst=1 for one edge while need=2'b01. need=0, work_done=1, feedback=0 after that edge. A late done rise is ignored.
- NUM_BANKS=4, ADDR_W=16: addr=16'h4000 selects need=4'b0010; addr=16'hC000 selects need=4'b1000. Feedback comes from the correct slice.

Source files
------------

// File: rtl/ram_bank_router.sv
// rtl/ram_bank_router.sv - routes one CPU access to one of NUM_BANKS RAM banks
//
// Purpose: accepts a held mem_rd/mem_wr request, raises a one-hot request to
// the bank selected by the top address bits and waits for a rising edge on
// that bank's done line (or a timeout). It then returns the bank's feedback
// and a level work_done to the memory stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_rd, mem_wr           CPU request levels, held until work_done
//   addr, wdata              CPU address and write data
//   ram_work_done            per-bank done levels
//   ram_feedback             per-bank feedback, bank k at [k*DATA_W +: DATA_W]
//   ram_need_to_work         one-hot bank request
//   ram_rd, ram_wr           latched operation
//   ram_addr, ram_wdata      latched address and write data
//   work_done                access complete, or nothing pending
//   feedback                 registered read result (all ones on timeout)
//   timeout_err              last access timed out
module ram_bank_router #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int NUM_BANKS   = 2,
    parameter int BANK_BITS   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_rd,
    input  logic                        mem_wr,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [NUM_BANKS-1:0]        ram_work_done,
    input  logic [NUM_BANKS*DATA_W-1:0] ram_feedback,
    output logic [NUM_BANKS-1:0]        ram_need_to_work,
    output logic                        ram_rd,
    output logic                        ram_wr,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    output logic                        work_done,
    output logic [DATA_W-1:0]           feedback,
    output logic                        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BANK_BITS-1:0]   r_sel;
    logic [NUM_BANKS-1:0]   r_done_prev;
    logic [31:0]            r_timer;
    logic [NUM_BANKS-1:0]   r_need;
    logic                   r_rd;
    logic                   r_wr;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_feedback;
    logic                   r_timeout_err;

    logic                   w_req;
    logic                   w_accept;
    logic                   w_complete;
    logic                   w_timeout;
    logic [BANK_BITS-1:0]   w_sel_in;
    logic [DATA_W-1:0]      w_fb_sel;

    assign w_req    = mem_rd | mem_wr;
    assign w_sel_in = addr[ADDR_W-1 -: BANK_BITS];

    // Only a rise on the latched bank counts; a level that was already high
    // when the request was accepted must fall and rise again.
    assign w_complete = ram_work_done[r_sel] & ~r_done_prev[r_sel];
    assign w_timeout  = (TIMEOUT_CYC != 0) && (r_timer == TMO_LAST);

    always_comb begin
        w_fb_sel = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (r_sel == k[BANK_BITS-1:0]) begin
                w_fb_sel = ram_feedback[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_complete || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // Stay until the CPU drops its request so a held level is
                // never issued twice.
                if (!w_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel         <= '0;
            r_done_prev   <= '0;
            r_timer       <= '0;
            r_need        <= '0;
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_feedback    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_prev <= ram_work_done;
            if (w_accept) begin
                r_sel         <= w_sel_in;
                r_addr        <= addr;
                r_wdata       <= wdata;
                r_wr          <= mem_wr;
                r_rd          <= mem_rd & ~mem_wr;
                r_need        <= NUM_BANKS'(1) << w_sel_in;
                r_timer       <= '0;
                r_timeout_err <= 1'b0;
            end
            if (r_state == BUSY) begin
                r_timer <= r_timer + 32'd1;
                // Completion takes priority over a coincident timeout.
                if (w_complete) begin
                    r_feedback <= w_fb_sel;
                    r_need     <= '0;
                end else if (w_timeout) begin
                    r_feedback    <= '1;
                    r_timeout_err <= 1'b1;
                    r_need        <= '0;
                end
            end
        end
    end

    assign ram_need_to_work = r_need;
    assign ram_rd           = r_rd;
    assign ram_wr           = r_wr;
    assign ram_addr         = r_addr;
    assign ram_wdata        = r_wdata;
    assign feedback         = r_feedback;
    assign timeout_err      = r_timeout_err;
    assign work_done        = (r_state == DONE) || ((r_state == IDLE) && !w_req);

endmodule

// File: tb/tb_ram_bank_router.sv
// tb/tb_ram_bank_router.sv - self-checking bench for ram_bank_router (2 and 4 banks)
module tb_ram_bank_router;

    logic        clk;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  bd;
    logic [63:0] bf;

    logic [1:0]  need2;
    logic        rd2, wr2, wd2, to2;
    logic [15:0] ra2, rw2, fb2;
    logic [3:0]  need4;
    logic        rd4, wr4, wd4, to4;
    logic [15:0] ra4, rw4, fb4;

    int n_vec = 0;
    int n_err = 0;

    ram_bank_router #(.ADDR_W(16), .DATA_W(16), .NUM_BANKS(2), .BANK_BITS(1), .TIMEOUT_CYC(8)) dut2 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .ram_work_done(bd[1:0]), .ram_feedback(bf[31:0]),
        .ram_need_to_work(need2), .ram_rd(rd2), .ram_wr(wr2), .ram_addr(ra2), .ram_wdata(rw2),
        .work_done(wd2), .feedback(fb2), .timeout_err(to2)
    );

    ram_bank_router #(.ADDR_W(16), .DATA_W(16), .NUM_BANKS(4), .BANK_BITS(2), .TIMEOUT_CYC(8)) dut4 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .ram_work_done(bd), .ram_feedback(bf),
        .ram_need_to_work(need4), .ram_rd(rd4), .ram_wr(wr4), .ram_addr(ra4), .ram_wdata(rw4),
        .work_done(wd4), .feedback(fb4), .timeout_err(to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] fb_base;
        logic        respond;
        logic        erd;
        logic        ewr;
        logic [1:0]  need2;
        logic [3:0]  need4;
        logic [15:0] fb2;
        logic [15:0] fb4;
        logic        to;
        int          lat;
    } vec_t;

    vec_t tbl[7];
    vec_t sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bank k returns base + k so a wrong slice shows up as a wrong value.
    task automatic set_fb(input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            bf[k*16 +: 16] = base + 16'(k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t e;
        int   lat;

        tbl[0] = '{1'b1, 1'b0, 16'h8004, 16'h0000, 16'hBEEE, 1'b1, 1'b1, 1'b0, 2'b10, 4'b0100, 16'hBEEF, 16'hBEF0, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'h5555, 1'b1, 1'b0, 1'b1, 2'b01, 4'b0001, 16'h5555, 16'h5555, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1000, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0010, 16'h1000, 16'h1001, 1'b0, 1};
        tbl[3] = '{1'b0, 1'b1, 16'hC000, 16'hABCD, 16'h2000, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1000, 16'h2001, 16'h2003, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h3000, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0010, 16'h3000, 16'h3001, 1'b0, 1};
        tbl[5] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b10, 4'b0100, 16'hFFFF, 16'hFFFF, 1'b1, 8};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h4000, 1'b1, 1'b1, 1'b0, 2'b01, 4'b0001, 16'h4000, 16'h4000, 1'b0, 1};

        rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; wdata = '0; bd = '0; bf = '0;
        step();
        step();
        chk("reset_need", {58'd0, need2, need4}, 64'd0);
        chk("reset_rdwr", {60'd0, rd2, wr2, rd4, wr4}, 64'd0);
        chk("reset_addr_wdata", {ra2, rw2, ra4, rw4}, 64'd0);
        chk("reset_fb_to", {30'd0, fb2, fb4, to2, to4}, 64'd0);
        chk("reset_work_done", {62'd0, wd2, wd4}, 64'd3);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            set_fb(v.fb_base);
            bd = '0;
            mem_rd = v.rd; mem_wr = v.wr; addr = v.addr; wdata = v.wdata;
            sb.push_back(v);
            #1;
            chk("accept_cycle_work_done", {62'd0, wd2, wd4}, 64'd0);
            step();
            chk("need_after_accept", {58'd0, need2, need4}, {58'd0, v.need2, v.need4});
            chk("op_after_accept", {60'd0, rd2, wr2, rd4, wr4}, {60'd0, v.erd, v.ewr, v.erd, v.ewr});
            chk("addr_wdata_latched", {ra2, rw2, ra4, rw4}, {v.addr, v.wdata, v.addr, v.wdata});
            chk("timeout_err_cleared", {62'd0, to2, to4}, 64'd0);
            if (v.respond) begin
                repeat (3) begin
                    step();
                    chk("busy_work_done", {62'd0, wd2, wd4}, 64'd0);
                end
                bd = 4'b1111;
            end
            lat = 0;
            while (!(wd2 && wd4) && lat < 20) begin
                step();
                lat++;
            end
            chk("completion_latency", 64'(lat), 64'(v.lat));
            e = sb.pop_front();
            chk("feedback", {32'd0, fb2, fb4}, {32'd0, e.fb2, e.fb4});
            chk("timeout_err", {62'd0, to2, to4}, {62'd0, e.to, e.to});
            chk("need_dropped", {58'd0, need2, need4}, 64'd0);
            step();
            chk("held_req_no_reissue", {56'd0, need2, need4, 2'b00, wd2, wd4}, 64'd3);
            mem_rd = 1'b0; mem_wr = 1'b0; bd = '0;
            step();
            chk("idle_after_drop", {56'd0, need2, need4, 2'b00, wd2, wd4}, 64'd3);
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        // Stale done: bank 0 done already high at accept must not complete.
        set_fb(16'h6000);
        bd = 4'b1111;
        step();
        step();
        mem_rd = 1'b1; addr = 16'h0000;
        step();
        chk("stale_need", {58'd0, need2, need4}, {58'd0, 2'b01, 4'b0001});
        repeat (4) begin
            step();
            chk("stale_work_done_low", {62'd0, wd2, wd4}, 64'd0);
        end
        bd = 4'b0000;
        step();
        chk("stale_fall_work_done_low", {62'd0, wd2, wd4}, 64'd0);
        bd = 4'b1111;
        step();
        chk("stale_rise_work_done", {62'd0, wd2, wd4}, 64'd3);
        chk("stale_feedback", {32'd0, fb2, fb4}, {32'd0, 16'h6000, 16'h6000});
        mem_rd = 1'b0; bd = '0;
        step();
        step();

        // Done on a non-selected bank is ignored.
        set_fb(16'h7000);
        mem_rd = 1'b1; addr = 16'h8000;
        step();
        bd = 4'b0001;
        step();
        step();
        chk("other_bank_ignored", {62'd0, wd2, wd4}, 64'd0);
        bd = 4'b0111;
        step();
        chk("sel_bank_completes", {62'd0, wd2, wd4}, 64'd3);
        chk("sel_bank_feedback", {32'd0, fb2, fb4}, {32'd0, 16'h7001, 16'h7002});
        mem_rd = 1'b0; bd = '0;
        step();
        step();

        // Reset while BUSY abandons the request; a late done is ignored.
        mem_rd = 1'b1; addr = 16'h0000;
        step();
        chk("rst_busy_need", {58'd0, need2, need4}, {58'd0, 2'b01, 4'b0001});
        rst = 1'b1; mem_rd = 1'b0;
        step();
        chk("rst_need_zero", {58'd0, need2, need4}, 64'd0);
        chk("rst_work_done", {62'd0, wd2, wd4}, 64'd3);
        chk("rst_feedback_zero", {32'd0, fb2, fb4}, 64'd0);
        rst = 1'b0; bd = 4'b1111;
        step();
        step();
        chk("late_done_need", {58'd0, need2, need4}, 64'd0);
        chk("late_done_feedback", {32'd0, fb2, fb4}, 64'd0);
        chk("late_done_work_done", {62'd0, wd2, wd4}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
